// File: rtl/fd_somador_sinal_magnitude_if.sv
// Operand/strobe/result bundle between the adder control unit and its datapath.
// The control unit drives the master side; the datapath is the slave.
interface fd_somador_sinal_magnitude_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         loadAB;
  logic         loadmagAB;
  logic         compmag;
  logic         compsigns;
  logic         add_sub;
  logic         loadres;
  logic [N-1:0] result;
  logic         overflow;
  logic         ready;
  logic         seq_err;

  modport master (
    output A, B, loadAB, loadmagAB, compmag, compsigns, add_sub, loadres,
    input  result, overflow, ready, seq_err
  );

  modport slave (
    input  A, B, loadAB, loadmagAB, compmag, compsigns, add_sub, loadres,
    output result, overflow, ready, seq_err
  );
endinterface

// File: rtl/fd_somador_sinal_magnitude.sv
// Sign-magnitude adder/subtractor datapath for two's-complement operands, stepped by
// one-hot strobes; also polices the strobe order and flags protocol violations.
module fd_somador_sinal_magnitude #(
  parameter int unsigned N = 8
) (
  input  logic                             clk,
  input  logic                             RESET,
  fd_somador_sinal_magnitude_if.slave      bus
);

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_AB   = 3'd1,
    P_MAG  = 3'd2,
    P_CMP  = 3'd3,
    P_SGN  = 3'd4,
    P_SUM  = 3'd5,
    P_RES  = 3'd6
  } phase_t;

  localparam logic [N:0] MaxPos = {2'b00, {(N-1){1'b1}}};
  localparam logic [N:0] MaxNeg = {2'b01, {(N-1){1'b0}}};

  phase_t       r_phase,     w_phase_d;
  logic [N-1:0] r_reg_a,     w_reg_a_d;
  logic [N-1:0] r_reg_b,     w_reg_b_d;
  logic         r_s_a,       w_s_a_d;
  logic         r_s_b,       w_s_b_d;
  logic [N-1:0] r_mag_a,     w_mag_a_d;
  logic [N-1:0] r_mag_b,     w_mag_b_d;
  logic         r_a_ge_b,    w_a_ge_b_d;
  logic         r_same_sign, w_same_sign_d;
  logic [N:0]   r_mag_r,     w_mag_r_d;
  logic         r_s_r,       w_s_r_d;
  logic [N-1:0] r_result,    w_result_d;
  logic         r_overflow,  w_overflow_d;
  logic         r_ready,     w_ready_d;
  logic         r_seq_err,   w_seq_err_d;

  logic [5:0]   w_strobes;
  logic         w_multi;
  logic [N:0]   w_sum;
  logic         w_s_sum;
  logic [N-1:0] w_res_low;

  assign w_strobes = {bus.loadAB, bus.loadmagAB, bus.compmag, bus.compsigns, bus.add_sub,
                      bus.loadres};
  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign w_multi   = |(w_strobes & (w_strobes - 6'd1));

  always_comb begin
    if (r_same_sign) begin
      w_sum   = {1'b0, r_mag_a} + {1'b0, r_mag_b};
      w_s_sum = r_s_a;
    end else if (r_a_ge_b) begin
      w_sum   = {1'b0, r_mag_a - r_mag_b};
      w_s_sum = r_s_a;
    end else begin
      w_sum   = {1'b0, r_mag_b - r_mag_a};
      w_s_sum = r_s_b;
    end
  end

  assign w_res_low = r_mag_r[N-1:0];

  always_comb begin
    w_phase_d     = r_phase;
    w_reg_a_d     = r_reg_a;
    w_reg_b_d     = r_reg_b;
    w_s_a_d       = r_s_a;
    w_s_b_d       = r_s_b;
    w_mag_a_d     = r_mag_a;
    w_mag_b_d     = r_mag_b;
    w_a_ge_b_d    = r_a_ge_b;
    w_same_sign_d = r_same_sign;
    w_mag_r_d     = r_mag_r;
    w_s_r_d       = r_s_r;
    w_result_d    = r_result;
    w_overflow_d  = r_overflow;
    w_ready_d     = r_ready;
    w_seq_err_d   = r_seq_err;

    if (w_multi) begin
      w_seq_err_d = 1'b1;
    end else if (bus.loadAB) begin
      w_reg_a_d   = bus.A;
      w_reg_b_d   = bus.B;
      w_s_a_d     = bus.A[N-1];
      w_s_b_d     = bus.B[N-1];
      w_ready_d   = 1'b0;
      w_seq_err_d = 1'b0;
      w_phase_d   = P_AB;
    end else if (bus.loadmagAB) begin
      if (r_phase == P_AB) begin
        w_mag_a_d = r_s_a ? (~r_reg_a + 1'b1) : r_reg_a;
        w_mag_b_d = r_s_b ? (~r_reg_b + 1'b1) : r_reg_b;
        w_phase_d = P_MAG;
      end else begin
        w_seq_err_d = 1'b1;
      end
    end else if (bus.compmag) begin
      if (r_phase == P_MAG) begin
        w_a_ge_b_d = (r_mag_a >= r_mag_b);
        w_phase_d  = P_CMP;
      end else begin
        w_seq_err_d = 1'b1;
      end
    end else if (bus.compsigns) begin
      if (r_phase == P_CMP) begin
        w_same_sign_d = (r_s_a == r_s_b);
        w_phase_d     = P_SGN;
      end else begin
        w_seq_err_d = 1'b1;
      end
    end else if (bus.add_sub) begin
      if (r_phase == P_SGN) begin
        w_mag_r_d = w_sum;
        w_s_r_d   = (w_sum == '0) ? 1'b0 : w_s_sum;
        w_phase_d = P_SUM;
      end else begin
        w_seq_err_d = 1'b1;
      end
    end else if (bus.loadres) begin
      if (r_phase == P_SUM) begin
        w_result_d   = r_s_r ? (~w_res_low + 1'b1) : w_res_low;
        w_overflow_d = r_s_r ? (r_mag_r > MaxNeg) : (r_mag_r > MaxPos);
        w_ready_d    = 1'b1;
        w_phase_d    = P_RES;
      end else if (r_phase != P_RES) begin
        // Held loadres in the control unit's done state is legal in P_RES.
        w_seq_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_phase     <= P_IDLE;
      r_reg_a     <= '0;
      r_reg_b     <= '0;
      r_s_a       <= 1'b0;
      r_s_b       <= 1'b0;
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_a_ge_b    <= 1'b0;
      r_same_sign <= 1'b0;
      r_mag_r     <= '0;
      r_s_r       <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_ready     <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_phase     <= w_phase_d;
      r_reg_a     <= w_reg_a_d;
      r_reg_b     <= w_reg_b_d;
      r_s_a       <= w_s_a_d;
      r_s_b       <= w_s_b_d;
      r_mag_a     <= w_mag_a_d;
      r_mag_b     <= w_mag_b_d;
      r_a_ge_b    <= w_a_ge_b_d;
      r_same_sign <= w_same_sign_d;
      r_mag_r     <= w_mag_r_d;
      r_s_r       <= w_s_r_d;
      r_result    <= w_result_d;
      r_overflow  <= w_overflow_d;
      r_ready     <= w_ready_d;
      r_seq_err   <= w_seq_err_d;
    end
  end

  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;
  assign bus.ready    = r_ready;
  assign bus.seq_err  = r_seq_err;

endmodule
